// File: rtl/tran_rec_arq.sv
// Store-and-forward serial frame transmitter with stop-and-wait ARQ.
// One frame is buffered in RAM, sent UART-style, and replayed on NAK/timeout.
module tran_rec_arq #(
   parameter int FRAME_BYTES  = 4164,
   parameter int CLKS_PER_BIT = 320,
   parameter int ACK_TIMEOUT  = 1000000,
   parameter int MAX_RETRIES  = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_frame_data,
   input  logic       i_frame_data_valid,
   input  logic       i_frame_data_fas,
   output logic       o_frame_data_ready,
   input  logic       i_arq_en,
   output logic       o_tx_serial,
   input  logic       i_ack_serial,
   output logic       o_send_complete,
   output logic       o_send_failed,
   output logic [3:0] o_retry_count,
   output logic [2:0] o_state
);

   localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int BW = $clog2(FRAME_BYTES + 1);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(ACK_TIMEOUT + 2 * CLKS_PER_BIT + 1);

   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BYTES - 1);
   localparam logic [BW-1:0] NBYTES    = BW'(FRAME_BYTES);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_SEND     = 3'd2,
      ST_ACK_WAIT = 3'd3,
      ST_ACK_RX   = 3'd4,
      ST_DONE     = 3'd5,
      ST_FAIL     = 3'd6
   } state_t;

   state_t         state_q, state_d;
   logic           ready_q, ready_d;
   logic           tx_q, tx_d;
   logic           complete_q, complete_d;
   logic           failed_q, failed_d;
   logic [3:0]     retry_q, retry_d;
   logic [AW-1:0]  wr_idx_q, wr_idx_d;
   logic [AW-1:0]  rd_addr_q, rd_addr_d;
   logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
   logic [7:0]     shreg_q, shreg_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [1:0]     rx_phase_q, rx_phase_d;
   logic           ack_bit_q, ack_bit_d;
   logic           ack_meta_q, ack_sync_q, ack_prev_q;

   logic [7:0]     mem [FRAME_BYTES];
   logic [7:0]     rd_data;
   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic           accept;
   logic           ack_fall;
   logic           start_send;
   logic           retry_req;

   // Frame buffer: one write port from the loader, synchronous read for the serialiser.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= i_frame_data;
      end
      rd_data <= mem[rd_addr_q];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_meta_q <= 1'b1;
         ack_sync_q <= 1'b1;
         ack_prev_q <= 1'b1;
      end else begin
         ack_meta_q <= i_ack_serial;
         ack_sync_q <= ack_meta_q;
         ack_prev_q <= ack_sync_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      wr_idx_d   = wr_idx_q;
      rd_addr_d  = (state_q == ST_SEND) ? rd_addr_q : '0;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      clk_cnt_d  = clk_cnt_q;
      shreg_d    = shreg_q;
      tmo_d      = tmo_q;
      rx_phase_d = rx_phase_q;
      ack_bit_d  = ack_bit_q;
      tx_d       = 1'b1;
      wr_en      = 1'b0;
      wr_addr    = '0;
      start_send = 1'b0;
      retry_req  = 1'b0;
      accept     = i_frame_data_valid & ready_q;
      ack_fall   = ack_prev_q & ~ack_sync_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && i_frame_data_fas) begin
               wr_en    = 1'b1;
               wr_idx_d = AW'(1);
               retry_d  = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               if (i_frame_data_fas) begin
                  wr_idx_d = AW'(1);
               end else begin
                  wr_addr = wr_idx_q;
                  if (wr_idx_q == LAST_ADDR) begin
                     wr_idx_d   = '0;
                     start_send = 1'b1;
                  end else begin
                     wr_idx_d = wr_idx_q + AW'(1);
                  end
               end
            end
         end
         ST_SEND: begin
            tx_d = tx_q;
            if (clk_cnt_q != BIT_LAST) begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end else begin
               clk_cnt_d = '0;
               if (bit_cnt_q == 4'd9) begin
                  if (byte_cnt_q == NBYTES) begin
                     tx_d    = 1'b1;
                     tmo_d   = '0;
                     state_d = i_arq_en ? ST_ACK_WAIT : ST_DONE;
                  end else begin
                     tx_d       = 1'b0;
                     bit_cnt_d  = 4'd0;
                     shreg_d    = rd_data;
                     byte_cnt_d = byte_cnt_q + BW'(1);
                  end
               end else if (bit_cnt_q == 4'd8) begin
                  // Entering the stop bit: prefetch the next byte so it is ready at the next start bit.
                  tx_d      = 1'b1;
                  bit_cnt_d = 4'd9;
                  rd_addr_d = (byte_cnt_q == NBYTES) ? '0 : byte_cnt_q[AW-1:0];
               end else begin
                  tx_d      = shreg_q[bit_cnt_q[2:0]];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         ST_ACK_WAIT: begin
            tmo_d = tmo_q + TW'(1);
            if (ack_fall) begin
               state_d    = ST_ACK_RX;
               clk_cnt_d  = '0;
               rx_phase_d = 2'd0;
            end else if (tmo_q >= TMO_LAST) begin
               retry_req = 1'b1;
            end
         end
         ST_ACK_RX: begin
            // The timeout keeps running here so a rejected false start does not extend the wait.
            tmo_d     = tmo_q + TW'(1);
            clk_cnt_d = clk_cnt_q + CW'(1);
            case (rx_phase_q)
               2'd0: begin
                  if (clk_cnt_q == HALF_LAST) begin
                     if (ack_sync_q) begin
                        state_d = ST_ACK_WAIT;
                     end else begin
                        rx_phase_d = 2'd1;
                        clk_cnt_d  = '0;
                     end
                  end
               end
               2'd1: begin
                  if (clk_cnt_q == BIT_LAST) begin
                     ack_bit_d  = ack_sync_q;
                     rx_phase_d = 2'd2;
                     clk_cnt_d  = '0;
                  end
               end
               default: begin
                  if (clk_cnt_q == BIT_LAST) begin
                     if (ack_sync_q && ack_bit_q) begin
                        state_d = ST_DONE;
                     end else begin
                        retry_req = 1'b1;
                     end
                  end
               end
            endcase
         end
         ST_DONE: state_d = ST_IDLE;
         ST_FAIL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (retry_req) begin
         if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
         end else begin
            retry_d    = retry_q + 4'd1;
            start_send = 1'b1;
         end
      end

      // Preload the counters as if a stop bit just ended, so byte 0 starts one clock after entry.
      if (start_send) begin
         state_d    = ST_SEND;
         bit_cnt_d  = 4'd9;
         clk_cnt_d  = BIT_LAST;
         byte_cnt_d = '0;
      end
   end

   assign ready_d    = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   assign complete_d = (state_d == ST_DONE);
   assign failed_d   = (state_d == ST_FAIL);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         tx_q       <= 1'b1;
         complete_q <= 1'b0;
         failed_q   <= 1'b0;
         retry_q    <= '0;
         wr_idx_q   <= '0;
         rd_addr_q  <= '0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= 4'd9;
         clk_cnt_q  <= '0;
         shreg_q    <= '0;
         tmo_q      <= '0;
         rx_phase_q <= '0;
         ack_bit_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         tx_q       <= tx_d;
         complete_q <= complete_d;
         failed_q   <= failed_d;
         retry_q    <= retry_d;
         wr_idx_q   <= wr_idx_d;
         rd_addr_q  <= rd_addr_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         clk_cnt_q  <= clk_cnt_d;
         shreg_q    <= shreg_d;
         tmo_q      <= tmo_d;
         rx_phase_q <= rx_phase_d;
         ack_bit_q  <= ack_bit_d;
      end
   end

   assign o_state            = state_q;
   assign o_frame_data_ready = ready_q;
   assign o_tx_serial        = tx_q;
   assign o_send_complete    = complete_q;
   assign o_send_failed      = failed_q;
   assign o_retry_count      = retry_q;

endmodule
